// File: rtl/req_issue_pkg.sv
// req_issue_pkg: shared types and constants for the request pulse issuer.
//   state_t      - issuer FSM states
//   DEF_*        - default parameter values
//   clog2_min1() - ceil(log2(n)), never less than 1, for id and counter widths
package req_issue_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_GNT = 2'd2,
    GUARD    = 2'd3
  } state_t;

  localparam int DEF_NUM_CLIENTS  = 4;
  localparam int DEF_GUARD_CYCLES = 1;
  localparam int DEF_TIMEOUT      = 8;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/req_pulse_issuer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_vec - level requests, one bit per client
//   last    - index of the client served last
//   winner  - first requesting index at or after last+1 (mod N)
//   valid   - at least one request present
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_vec,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] winner,
  output logic            valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // Walk N positions starting just after the last served client; the
    // wrap keeps idx below N, so the truncated index is always in range.
    for (int i = 1; i <= N; i++) begin
      idx = int'(last) + i;
      if (idx >= N) idx = idx - N;
      if (!valid && req_vec[idx[ID_W-1:0]]) begin
        valid  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/req_pulse_issuer.sv
// req_pulse_issuer: round-robin arbiter that turns level-held client requests
// into single-cycle req pulses for a downstream grant-echo stage.
//   clk          - clock, all state on posedge
//   reset        - asynchronous active-high reset
//   client_req   - level request per client, held until client_ack
//   client_ack   - one-hot, one-cycle acknowledge after the grant
//   req          - one-cycle pulse downstream
//   gnt          - downstream echo of req
//   active_id    - client currently being served
//   busy         - high in every state except IDLE
//   timeout_err  - one-cycle pulse when the grant wait expires
//   protocol_err - one-cycle pulse on gnt outside WAIT_GNT
module req_pulse_issuer
  import req_issue_pkg::*;
#(
  parameter int NUM_CLIENTS  = DEF_NUM_CLIENTS,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLIENTS-1:0]         client_req,
  output logic [NUM_CLIENTS-1:0]         client_ack,
  output logic                           req,
  input  logic                           gnt,
  output logic [$clog2(NUM_CLIENTS)-1:0] active_id,
  output logic                           busy,
  output logic                           timeout_err,
  output logic                           protocol_err
);

  localparam int ID_W  = clog2_min1(NUM_CLIENTS);
  localparam int CNT_W = clog2_min1(TIMEOUT + 1);
  localparam int GD_W  = clog2_min1(GUARD_CYCLES);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GD_W-1:0]  G_LAST  = GD_W'(GUARD_CYCLES - 1);
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_CLIENTS - 1);

  state_t state, state_n;

  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic [GD_W-1:0]  guard_cnt;
  logic [ID_W-1:0]  arb_winner;
  logic             arb_valid;
  logic             grant_hit;
  logic             expire;

  rr_arbiter #(
    .N    (NUM_CLIENTS),
    .ID_W (ID_W)
  ) u_arb (
    .req_vec (client_req),
    .last    (ptr),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  // A grant on the final wait cycle wins over the timeout.
  assign grant_hit = (state == WAIT_GNT) && gnt;
  assign expire    = (state == WAIT_GNT) && !gnt && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    req     = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (arb_valid) state_n = ISSUE;
      end
      ISSUE: begin
        req     = 1'b1;
        state_n = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (grant_hit || expire) state_n = GUARD;
      end
      GUARD: begin
        if (guard_cnt == G_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= PTR_RST;
      active_id    <= '0;
      wait_cnt     <= '0;
      guard_cnt    <= '0;
      client_ack   <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (state == IDLE && arb_valid) active_id <= arb_winner;

      client_ack   <= grant_hit ? (NUM_CLIENTS'(1) << active_id) : '0;
      timeout_err  <= expire;
      protocol_err <= gnt && (state != WAIT_GNT);

      // Advancing the pointer on timeout too keeps a dead downstream path
      // from locking the same client at the head of the rotation.
      if (grant_hit || expire) ptr <= active_id;

      if (state == WAIT_GNT && state_n == WAIT_GNT) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state == GUARD && state_n == GUARD) guard_cnt <= guard_cnt + 1'b1;
      else                                    guard_cnt <= '0;
    end
  end

  a_req_single: assert property (@(posedge clk) disable iff (reset) req |=> !req)
    else $error("req_pulse_issuer: req high on consecutive cycles at %0t", $time);

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(client_ack))
    else $error("req_pulse_issuer: client_ack not one-hot at %0t", $time);

  a_ack_after_gnt: assert property (@(posedge clk) disable iff (reset)
    (|client_ack) |-> $past(gnt, 1))
    else $error("req_pulse_issuer: client_ack without prior gnt at %0t", $time);

  // req must stay low through the wait and guard window after each pulse.
  for (genvar k = 1; k <= GUARD_CYCLES + 2; k++) begin : g_req_low
    a_req_low: assert property (@(posedge clk) disable iff (reset)
      $past(req, k) |-> !req)
      else $error("req_pulse_issuer: req re-raised inside guard window at %0t", $time);
  end

endmodule

// File: tb/tb_req_pulse_issuer.sv
module tb_req_pulse_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] client_req;
  logic [3:0] client_ack;
  logic       req;
  logic       gnt;
  logic [1:0] active_id;
  logic       busy;
  logic       timeout_err;
  logic       protocol_err;

  logic echo_en   = 1'b1;
  logic force_gnt = 1'b0;
  logic echo_q    = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int te_cnt   = 0;
  int pe_cnt   = 0;
  int dbl_cnt  = 0;
  logic prev_req = 1'b0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Downstream grant-echo stage, or a forced level when echo is disabled.
  always @(posedge clk) echo_q <= req;
  assign gnt = echo_en ? echo_q : force_gnt;

  always @(negedge clk) begin
    if (timeout_err === 1'b1) te_cnt <= te_cnt + 1;
    if (protocol_err === 1'b1) pe_cnt <= pe_cnt + 1;
    if (req === 1'b1 && prev_req === 1'b1) dbl_cnt <= dbl_cnt + 1;
    prev_req <= req;
  end

  req_pulse_issuer dut (
    .clk          (clk),
    .reset        (reset),
    .client_req   (client_req),
    .client_ack   (client_ack),
    .req          (req),
    .gnt          (gnt),
    .active_id    (active_id),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_req(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (req === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check("req_seen", 32'(at != -1), 32'd1);
  endtask

  task automatic wait_ack(input int bound, output int at);
    int exp_id;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (client_ack !== 4'b0000) begin
        at = cyc;
        break;
      end
    end
    check("ack_seen", 32'(at != -1), 32'd1);
    if (exp_q.size() > 0) begin
      exp_id = exp_q.pop_front();
      check("ack_vec", 32'(client_ack), 32'(1) << exp_id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, a, prev, te_at;

    reset = 1'b1;
    client_req = 4'b0000;
    step();
    step();
    check("rst_req", 32'(req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(client_ack), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    check("rst_te", 32'(timeout_err), 32'd0);
    check("rst_pe", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    step();

    // Single client with echo downstream.
    client_req = 4'b0001;
    prev = cyc;
    exp_q.push_back(0);
    wait_req(8, r);
    check("t1_req_lat", 32'(r - prev), 32'd1);
    check("t1_id", 32'(active_id), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_ack(6, a);
    check("t1_ack_lat", 32'(a - r), 32'd2);
    client_req = 4'b0000;
    step();
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_te", 32'(te_cnt), 32'd0);
    check("t1_pe", 32'(pe_cnt), 32'd0);

    // All four clients continuously, starting from a fresh pointer.
    do_reset();
    client_req = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_req(8, r);
      if (exp_q.size() > 0) check("t2_id", 32'(active_id), 32'(exp_q[0]));
      if (prev >= 0) check("t2_spacing", 32'(r - prev), 32'd4);
      prev = r;
      wait_ack(6, a);
      check("t2_ack_lat", 32'(a - r), 32'd2);
    end
    client_req = 4'b0000;
    step();
    step();
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_no_double_req", 32'(dbl_cnt), 32'd0);

    // Dead downstream: timeout, then another client still gets served.
    do_reset();
    echo_en = 1'b0;
    force_gnt = 1'b0;
    client_req = 4'b0001;
    wait_req(8, r);
    a = 0;
    te_at = -1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (client_ack !== 4'b0000) a++;
      if (timeout_err === 1'b1) begin
        te_at = cyc;
        break;
      end
    end
    check("t3_te_lat", 32'(te_at - r), 32'd9);
    check("t3_no_ack", 32'(a), 32'd0);
    client_req = 4'b0011;
    echo_en = 1'b1;
    exp_q.push_back(1);
    wait_req(8, r);
    check("t3_next_id", 32'(active_id), 32'd1);
    wait_ack(6, a);
    client_req = 4'b0000;
    step();
    step();
    check("t3_te_once", 32'(te_cnt), 32'd1);

    // gnt forced high while idle.
    echo_en = 1'b0;
    force_gnt = 1'b1;
    step();
    check("t4_pe", 32'(protocol_err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    force_gnt = 1'b0;
    step();
    check("t4_pe_clear", 32'(protocol_err), 32'd0);
    check("t4_still_idle", 32'(busy), 32'd0);
    check("t4_pe_once", 32'(pe_cnt), 32'd1);

    // Asynchronous reset in the middle of the grant wait.
    client_req = 4'b0001;
    wait_req(8, r);
    step();
    check("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_busy_async", 32'(busy), 32'd0);
    check("t5_req_async", 32'(req), 32'd0);
    check("t5_ack_async", 32'(client_ack), 32'd0);
    client_req = 4'b0000;
    step();
    step();
    reset = 1'b0;
    echo_en = 1'b1;
    client_req = 4'b0100;
    exp_q.push_back(2);
    wait_req(8, r);
    check("t5_id", 32'(active_id), 32'd2);
    wait_ack(6, a);
    check("t5_ack_lat", 32'(a - r), 32'd2);
    client_req = 4'b0000;
    step();
    step();

    // gnt exactly on the last wait cycle counts as a grant.
    echo_en = 1'b0;
    force_gnt = 1'b0;
    client_req = 4'b0001;
    exp_q.push_back(0);
    wait_req(8, r);
    repeat (8) step();
    force_gnt = 1'b1;
    wait_ack(3, a);
    force_gnt = 1'b0;
    check("t6_ack_lat", 32'(a - r), 32'd9);
    check("t6_te", 32'(timeout_err), 32'd0);
    client_req = 4'b0000;
    step();
    step();
    check("t6_te_total", 32'(te_cnt), 32'd1);
    check("t6_pe_total", 32'(pe_cnt), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
